gray_seq_monitor: RTL

- Downstream consumer of the Gray-code counter stage; samples its `gray_cnt`/`sig` outputs every clock.
- Decodes Gray to binary and counts wrap pulses.
- Checks that each new sample is a legal single-step successor of the previous one and that `sig` is consistent with the count.
- Drives registered status and fault flags for the formal and simulation harnesses.

---
 rtl/gray_seq_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor: consumes an upstream Gray-code counter, decodes it to
// binary, counts wrap pulses and flags illegal steps or inconsistent sig.
module gray_seq_monitor #(
    parameter int CBITS = 14,
    parameter int WBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CBITS-1:0] gray_in,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CBITS-1:0] bin_out,
    output logic [WBITS-1:0] wrap_cnt,
    output logic             locked,
    output logic             fault,
    output logic             err_step,
    output logic             err_sig,
    output logic [1:0]       err_sticky
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [CBITS-1:0] ONE = {{(CBITS-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [CBITS-1:0] prev_gray_p1;

    logic             accept;
    logic             sig_bad;
    logic             step_bad;
    logic             capture;
    logic [CBITS-1:0] bin_in;
    logic [CBITS-1:0] bin_prev;
    logic [CBITS-1:0] bin_succ;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CBITS-1:0] gray2bin(input logic [CBITS-1:0] g);
        logic [CBITS-1:0] b;
        b = '0;
        b[CBITS-1] = g[CBITS-1];
        for (int i = CBITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when exactly one bit of d is set.
    function automatic logic one_hot(input logic [CBITS-1:0] d);
        return (d != '0) && ((d & (d - ONE)) == '0);
    endfunction

    assign bin_in   = gray2bin(gray_in);
    assign bin_prev = gray2bin(prev_gray_p1);
    assign bin_succ = bin_prev + ONE;

    // Classify the current sample: accepted or not, and which checks fail.
    always_comb begin
        accept   = 1'b0;
        sig_bad  = 1'b0;
        step_bad = 1'b0;
        capture  = 1'b0;
        if (in_valid && !clr && (state == UNLOCKED || state == LOCKED)) begin
            accept  = 1'b1;
            sig_bad = (sig_in != (gray_in == '0));
            if (state == LOCKED) begin
                step_bad = !(one_hot(gray_in ^ prev_gray_p1) && (bin_in == bin_succ));
            end
            capture = !sig_bad && !step_bad;
        end
    end

    // Next-state logic; clr always returns to UNLOCKED and drops any sample.
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED, LOCKED: begin
                if (clr) begin
                    state_nxt = UNLOCKED;
                end else if (accept) begin
                    state_nxt = (sig_bad || step_bad) ? FAULT : LOCKED;
                end
            end
            FAULT: begin
                if (clr) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Sample capture, wrap counting and error flags; failing samples are not captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_p1 <= '0;
            bin_out      <= '0;
            wrap_cnt     <= '0;
            err_step     <= 1'b0;
            err_sig      <= 1'b0;
            err_sticky   <= 2'b00;
        end else begin
            if (capture) begin
                prev_gray_p1 <= gray_in;
                bin_out      <= bin_in;
            end
            if (accept && sig_in && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + {{(WBITS-1){1'b0}}, 1'b1};
            end
            err_step <= step_bad;
            err_sig  <= sig_bad;
            if (clr) begin
                err_sticky <= 2'b00;
            end else begin
                err_sticky <= err_sticky | {sig_bad, step_bad};
            end
        end
    end

    assign locked = (state == LOCKED);
    assign fault  = (state == FAULT);

endmodule
